// File: rtl/quad_encoder_emulator_pkg.sv
// Shared encoder phase constants, FSM state codes and Gray-phase stepping helpers.
// Pure definitions, no timing; no backpressure.
package quad_encoder_emulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUNCE,
    ST_DWELL
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  function automatic logic [1:0] phase_next(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  function automatic logic [1:0] phase_prev(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // cw = 1 walks the clockwise sequence 00->10->11->01.
  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic cw);
    return cw ? phase_next(ph) : phase_prev(ph);
  endfunction

endpackage

// File: rtl/quad_encoder_emulator_if.sv
// Step-command bus: valid/ready handshake plus direction, step count and abort level.
// Combinational bundle; ready is low for the whole of a running command.
interface quad_encoder_emulator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_count;
  logic       abort;

  modport master (output cmd_valid, cmd_dir, cmd_count, abort, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dir, cmd_count, abort, output cmd_ready);
endinterface

// File: rtl/qenc_interval_timer.sv
// Down-counting interval timer: start loads N, expire is high in the Nth cycle after start.
// Restart has priority over expiry; no backpressure.
module qenc_interval_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (start)      cnt <= load;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/quad_encoder_emulator.sv
// Rotary-encoder emulator: emits N Gray steps with optional bounce, tracks net settled position.
// Encoder moves on the accepting edge; cmd_ready is low while busy (no queueing).
module quad_encoder_emulator
  import quad_encoder_emulator_pkg::*;
#(
  parameter int DWELL_CYCLES  = 50000,
  parameter int BOUNCE_PULSES = 0,
  parameter int BOUNCE_LEN    = 500,
  parameter int POS_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  quad_encoder_emulator_if.slave  cmd,
  output logic [1:0]              encoder,
  output logic                    busy,
  output logic                    done,
  output logic [POS_W-1:0]        position
);

  localparam int TMAX = (DWELL_CYCLES > BOUNCE_LEN) ? DWELL_CYCLES : BOUNCE_LEN;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int HW   = $clog2(2 * BOUNCE_PULSES + 1) + 1;

  state_t           state, state_nxt;
  logic [1:0]       ph, ph_nxt;
  logic [1:0]       enc_nxt;
  logic             dir, dir_nxt;
  logic [7:0]       rem, rem_nxt;
  logic [HW-1:0]    half, half_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             done_nxt;
  logic             tmr_start, tmr_expire;
  logic [TW-1:0]    tmr_load;
  logic             launch, launch_dir, settle;
  logic [1:0]       tgt;

  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p, input logic cw);
    return cw ? p + POS_W'(1) : p - POS_W'(1);
  endfunction

  qenc_interval_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tmr_start),
    .load   (tmr_load),
    .expire (tmr_expire)
  );

  assign busy          = (state != ST_IDLE);
  assign cmd.cmd_ready = ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ph       <= PH_00;
      encoder  <= PH_00;
      dir      <= 1'b0;
      rem      <= '0;
      half     <= '0;
      position <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ph       <= ph_nxt;
      encoder  <= enc_nxt;
      dir      <= dir_nxt;
      rem      <= rem_nxt;
      half     <= half_nxt;
      position <= pos_nxt;
      done     <= done_nxt;
    end
  end

  // ph is always the settled (target) phase; encoder may show the old phase during bounce.
  always_comb begin
    state_nxt  = state;
    ph_nxt     = ph;
    enc_nxt    = encoder;
    dir_nxt    = dir;
    rem_nxt    = rem;
    half_nxt   = half;
    pos_nxt    = position;
    done_nxt   = 1'b0;
    tmr_start  = 1'b0;
    tmr_load   = TW'(DWELL_CYCLES);
    launch     = 1'b0;
    launch_dir = dir;
    settle     = 1'b0;
    tgt        = ph;

    case (state)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          if (cmd.cmd_count == 8'd0) begin
            done_nxt = 1'b1;
          end else begin
            rem_nxt    = cmd.cmd_count;
            dir_nxt    = cmd.cmd_dir;
            launch     = 1'b1;
            launch_dir = cmd.cmd_dir;
          end
        end
      end
      ST_BOUNCE: begin
        if (cmd.abort) begin
          enc_nxt   = ph;
          pos_nxt   = pos_step(position, dir);
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (tmr_expire) begin
          if (half == '0) begin
            settle = 1'b1;
          end else begin
            half_nxt  = half - 1'b1;
            enc_nxt   = (encoder == ph) ? phase_step(ph, ~dir) : ph;
            tmr_start = 1'b1;
            tmr_load  = TW'(BOUNCE_LEN);
          end
        end
      end
      ST_DWELL: begin
        if (cmd.abort) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (tmr_expire) begin
          if (rem == 8'd1) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            rem_nxt    = rem - 8'd1;
            launch     = 1'b1;
            launch_dir = dir;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (settle) begin
      state_nxt = ST_DWELL;
      enc_nxt   = ph;
      pos_nxt   = pos_step(position, dir);
      tmr_start = 1'b1;
      tmr_load  = TW'(DWELL_CYCLES);
    end

    if (launch) begin
      tgt       = phase_step(ph, launch_dir);
      ph_nxt    = tgt;
      enc_nxt   = tgt;
      tmr_start = 1'b1;
      if (BOUNCE_PULSES > 0) begin
        state_nxt = ST_BOUNCE;
        half_nxt  = HW'(2 * BOUNCE_PULSES - 1);
        tmr_load  = TW'(BOUNCE_LEN);
      end else begin
        state_nxt = ST_DWELL;
        pos_nxt   = pos_step(position, launch_dir);
        tmr_load  = TW'(DWELL_CYCLES);
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Bench: a clean and a bouncing emulator instance, per-cycle {encoder,busy,done} scoreboard.
module tb_quad_encoder_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  enc0, enc1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] pos0, pos1;

  logic [3:0]  q0[$];
  logic [3:0]  q1[$];
  logic [1:0]  m_ph[2];
  logic [15:0] m_pos[2];
  int          n_chk = 0;
  int          n_pass = 0;

  quad_encoder_emulator_if if0();
  quad_encoder_emulator_if if1();

  quad_encoder_emulator #(.DWELL_CYCLES(4), .BOUNCE_PULSES(0), .BOUNCE_LEN(3), .POS_W(16)) u_clean (
    .clk(clk), .rst_n(rst_n), .cmd(if0), .encoder(enc0), .busy(busy0), .done(done0), .position(pos0)
  );

  quad_encoder_emulator #(.DWELL_CYCLES(4), .BOUNCE_PULSES(2), .BOUNCE_LEN(3), .POS_W(16)) u_bounce (
    .clk(clk), .rst_n(rst_n), .cmd(if1), .encoder(enc1), .busy(busy1), .done(done1), .position(pos1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] ph_step(input logic [1:0] p, input logic cw);
    case (p)
      2'b00:   return cw ? 2'b10 : 2'b01;
      2'b10:   return cw ? 2'b11 : 2'b00;
      2'b11:   return cw ? 2'b01 : 2'b10;
      default: return cw ? 2'b00 : 2'b11;
    endcase
  endfunction

  always @(negedge clk)
    if (q0.size() > 0) check("clean_seq", 32'({enc0, busy0, done0}), 32'(q0.pop_front()));

  always @(negedge clk)
    if (q1.size() > 0) check("bounce_seq", 32'({enc1, busy1, done1}), 32'(q1.pop_front()));

  // ab = N asserts abort so that it is sampled N edges after the accepting edge (0 = never).
  task automatic send(input int d, input logic dir, input int cnt, input int ab, input bit track);
    logic [3:0]  exp[$];
    logic [1:0]  ph, nw;
    logic [15:0] dlt;
    int          n, bp;
    bit          stop;
    bp   = (d == 1) ? 2 : 0;
    ph   = m_ph[d];
    dlt  = dir ? 16'd1 : 16'hFFFF;
    n    = 0;
    stop = 1'b0;
    for (int s = 0; s < cnt && !stop; s++) begin
      nw = ph_step(ph, dir);
      for (int h = 0; h < 2 * bp && !stop; h++)
        for (int c = 0; c < 3 && !stop; c++) begin
          exp.push_back({((h % 2) == 0) ? nw : ph, 2'b10});
          n++;
          if (n == ab) begin stop = 1'b1; m_pos[d] += dlt; end
        end
      if (!stop) begin
        m_pos[d] += dlt;
        for (int c = 0; c < 4 && !stop; c++) begin
          exp.push_back({nw, 2'b10});
          n++;
          if (n == ab) stop = 1'b1;
        end
      end
      ph = nw;
    end
    exp.push_back({ph, 2'b01});
    exp.push_back({ph, 2'b00});
    m_ph[d] = ph;

    @(negedge clk); #1;
    if (track) foreach (exp[i]) begin
      if (d == 0) q0.push_back(exp[i]); else q1.push_back(exp[i]);
    end
    if (d == 0) begin if0.cmd_valid = 1'b1; if0.cmd_dir = dir; if0.cmd_count = 8'(cnt); end
    else        begin if1.cmd_valid = 1'b1; if1.cmd_dir = dir; if1.cmd_count = 8'(cnt); end
    @(posedge clk); #1;
    if0.cmd_valid = 1'b0;
    if1.cmd_valid = 1'b0;
    if (ab > 0) begin
      repeat (ab - 1) @(posedge clk);
      #1;
      if (d == 0) if0.abort = 1'b1; else if1.abort = 1'b1;
      @(posedge clk); #1;
      if0.abort = 1'b0;
      if1.abort = 1'b0;
    end
    if (track) begin
      for (int i = 0; i < 400 && ((d == 0) ? q0.size() : q1.size()) > 0; i++) begin
        @(negedge clk); #1;
      end
      check("drain", (d == 0) ? q0.size() : q1.size(), 0);
      check("position", 32'((d == 0) ? pos0 : pos1), 32'(m_pos[d]));
      check("ready", 32'((d == 0) ? if0.cmd_ready : if1.cmd_ready), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    if0.cmd_valid = 1'b0; if0.cmd_dir = 1'b0; if0.cmd_count = 8'd0; if0.abort = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_dir = 1'b0; if1.cmd_count = 8'd0; if1.abort = 1'b0;
    m_ph[0] = 2'b00; m_ph[1] = 2'b00; m_pos[0] = 16'd0; m_pos[1] = 16'd0;
    rst_n = 1'b0;
    #3;
    check("rst_enc",   32'(enc0), 32'd0);
    check("rst_ready", 32'(if0.cmd_ready), 32'd1);
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_done",  32'(done0), 32'd0);
    check("rst_pos",   32'(pos0), 32'd0);
    check("rst_enc_b", 32'(enc1), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(0, 1'b1, 4, 0, 1'b1);   // clean CW x4: 10,11,01,00
    send(1, 1'b1, 1, 0, 1'b1);   // bounced CW x1: 10,00,10,00 then 10
    send(1, 1'b1, 3, 1, 1'b1);   // abort in first bounce half settles on 11

    send(0, 1'b1, 3, 0, 1'b0);   // reset lands mid-dwell
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_enc",   32'(enc0), 32'd0);
    check("arst_busy",  32'(busy0), 32'd0);
    check("arst_pos",   32'(pos0), 32'd0);
    check("arst_ready", 32'(if0.cmd_ready), 32'd1);
    check("arst_pos_b", 32'(pos1), 32'd0);
    m_ph[0] = 2'b00; m_ph[1] = 2'b00; m_pos[0] = 16'd0; m_pos[1] = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;

    send(0, 1'b0, 2, 0, 1'b1);   // CCW x2 from 00: 01,11, position FFFE
    send(0, 1'b1, 0, 0, 1'b1);   // zero-count command: one DONE, nothing moves
    send(0, 1'b1, 5, 6, 1'b1);   // abort during step-2 dwell, position wraps to 0000

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
